// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: access FSM encoding,
// ALU flag bit positions, the write-back record and an alignment helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    localparam int FLAG_O = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

    // Everything the write-back stage consumes, held as one register.
    typedef struct packed {
        logic        valid;
        logic [31:0] mxpc;
        logic [31:0] dm_q;
        logic [31:0] alu;
        logic [1:0]  s_mxrb;
        logic [2:0]  w_rf;
        logic        w_rb;
        logic [3:0]  flags;
    } wb_rec_t;

    // Word accesses require the two low address bits to be zero.
    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/dm_handshake.sv
// Data-memory access sequencer: issues one request per memory instruction,
// waits for dm_ack with a timeout, captures load data and raises a sticky
// bus error on timeout or misaligned address.
module dm_handshake
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_op,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output mem_state_e  state,
    output logic        busy,
    output logic [31:0] cap_data,
    output logic        bus_err
);

    // Counter only needs to reach TIMEOUT-1; the TIMEOUT-th cycle aborts.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_e    state_r;
    mem_state_e    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          dm_req_r;
    logic          dm_we_r;
    logic [31:0]   dm_addr_r;
    logic [31:0]   dm_wdata_r;
    logic [31:0]   cap_data_r;
    logic          bus_err_r;
    logic          issue_s;
    logic          ack_s;
    logic          tmo_s;
    logic          misalign_s;

    // Next-state and event decode; an ack in the final cycle beats the timeout.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        issue_s     = 1'b0;
        ack_s       = 1'b0;
        tmo_s       = 1'b0;
        misalign_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (mem_op) begin
                    if (word_aligned(addr)) begin
                        issue_s     = 1'b1;
                        state_nxt_s = ST_ACCESS;
                    end else begin
                        misalign_s  = 1'b1;
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (dm_ack) begin
                    ack_s       = 1'b1;
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    tmo_s       = 1'b1;
                    cnt_nxt_s   = CNT_ZERO;
                    state_nxt_s = ST_DONE;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Access state, timeout counter, memory interface and captured data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            dm_req_r   <= 1'b0;
            dm_we_r    <= 1'b0;
            dm_addr_r  <= 32'h0000_0000;
            dm_wdata_r <= 32'h0000_0000;
            cap_data_r <= 32'h0000_0000;
            bus_err_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (issue_s) begin
                dm_req_r   <= 1'b1;
                dm_we_r    <= is_store;
                dm_addr_r  <= addr;
                dm_wdata_r <= wdata;
            end else if (ack_s || tmo_s) begin
                dm_req_r <= 1'b0;
                dm_we_r  <= 1'b0;
            end
            if (ack_s) begin
                cap_data_r <= dm_we_r ? 32'h0000_0000 : dm_rdata;
            end else if (tmo_s || misalign_s) begin
                cap_data_r <= 32'h0000_0000;
            end
            if (tmo_s || misalign_s) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    assign busy     = ((state_r == ST_IDLE) && mem_op) || (state_r == ST_ACCESS);
    assign state    = state_r;
    assign dm_req   = dm_req_r;
    assign dm_we    = dm_we_r;
    assign dm_addr  = dm_addr_r;
    assign dm_wdata = dm_wdata_r;
    assign cap_data = cap_data_r;
    assign bus_err  = bus_err_r;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs loads/stores through dm_handshake, stalls EX
// while an access is outstanding and holds the write-back pipeline register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_mxpc_out,
    input  logic [1:0]  ex_uc_S_MXRB,
    input  logic [2:0]  ex_uc_W_RF,
    input  logic        ex_uc_W_RB,
    input  logic        ex_uc_R_DM,
    input  logic        ex_uc_W_DM,
    input  logic [3:0]  ex_alu_flags,
    output logic        stall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_mxpc_out,
    output logic [31:0] wb_dm_Q,
    output logic [31:0] wb_alu_result,
    output logic [1:0]  wb_uc_S_MXRB,
    output logic [2:0]  wb_uc_W_RF,
    output logic        wb_uc_W_RB,
    output logic        wb_alu_O,
    output logic        wb_alu_S,
    output logic        wb_alu_C,
    output logic        wb_alu_Z,
    output logic        bus_err
);

    mem_state_e  state_s;
    logic        mem_op_s;
    logic        busy_s;
    logic [31:0] cap_data_s;
    logic        wb_load_s;
    logic        wb_cap_s;
    wb_rec_t     wb_r;

    // A load with the store bit also set is handled as a store.
    assign mem_op_s = ex_valid && (ex_uc_R_DM || ex_uc_W_DM);

    dm_handshake #(
        .TIMEOUT (TIMEOUT)
    ) u_dm_handshake (
        .clk      (CLK),
        .rst_n    (RST_N),
        .mem_op   (mem_op_s),
        .is_store (ex_uc_W_DM),
        .addr     (ex_alu_result),
        .wdata    (ex_store_data),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .state    (state_s),
        .busy     (busy_s),
        .cap_data (cap_data_s),
        .bus_err  (bus_err)
    );

    // Stall is combinational so EX holds in the very cycle a memory op appears.
    assign stall = RST_N && busy_s;

    // Decide when the WB register takes a real instruction.
    always_comb begin
        wb_load_s = 1'b0;
        wb_cap_s  = 1'b0;
        case (state_s)
            ST_IDLE: begin
                if (ex_valid && !mem_op_s) begin
                    wb_load_s = 1'b1;
                end else begin
                    wb_load_s = 1'b0;
                end
            end
            ST_DONE: begin
                wb_load_s = 1'b1;
                wb_cap_s  = 1'b1;
            end
            ST_ACCESS: begin
                wb_load_s = 1'b0;
            end
            default: begin
                wb_load_s = 1'b0;
            end
        endcase
    end

    // Write-back register; bubbles also kill both write enables.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wb_r <= '0;
        end else if (wb_load_s) begin
            wb_r.valid  <= 1'b1;
            wb_r.mxpc   <= ex_mxpc_out;
            wb_r.alu    <= ex_alu_result;
            wb_r.s_mxrb <= ex_uc_S_MXRB;
            wb_r.w_rf   <= ex_uc_W_RF;
            wb_r.w_rb   <= ex_uc_W_RB;
            wb_r.flags  <= ex_alu_flags;
            if (wb_cap_s) begin
                wb_r.dm_q <= cap_data_s;
            end
        end else begin
            wb_r.valid <= 1'b0;
            wb_r.w_rf  <= 3'b000;
            wb_r.w_rb  <= 1'b0;
        end
    end

    assign wb_valid      = wb_r.valid;
    assign wb_mxpc_out   = wb_r.mxpc;
    assign wb_dm_Q       = wb_r.dm_q;
    assign wb_alu_result = wb_r.alu;
    assign wb_uc_S_MXRB  = wb_r.s_mxrb;
    assign wb_uc_W_RF    = wb_r.w_rf;
    assign wb_uc_W_RB    = wb_r.w_rb;
    assign wb_alu_O      = wb_r.flags[FLAG_O];
    assign wb_alu_S      = wb_r.flags[FLAG_S];
    assign wb_alu_C      = wb_r.flags[FLAG_C];
    assign wb_alu_Z      = wb_r.flags[FLAG_Z];

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues instructions and pushes the
// expected WB record and memory request; a responder plays the data memory
// and a monitor checks every WB cycle against the queued expectations.
module tb_mem_stage;

    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_alu_result = 32'h0;
    logic [31:0] ex_store_data = 32'h0;
    logic [31:0] ex_mxpc_out = 32'h0;
    logic [1:0]  ex_uc_S_MXRB = 2'b00;
    logic [2:0]  ex_uc_W_RF = 3'b000;
    logic        ex_uc_W_RB = 1'b0;
    logic        ex_uc_R_DM = 1'b0;
    logic        ex_uc_W_DM = 1'b0;
    logic [3:0]  ex_alu_flags = 4'h0;
    logic        stall, dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = 32'h0;
    logic        wb_valid;
    logic [31:0] wb_mxpc_out, wb_dm_Q, wb_alu_result;
    logic [1:0]  wb_uc_S_MXRB;
    logic [2:0]  wb_uc_W_RF;
    logic        wb_uc_W_RB, wb_alu_O, wb_alu_S, wb_alu_C, wb_alu_Z, bus_err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST_N(RST_N), .ex_valid(ex_valid),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mxpc_out(ex_mxpc_out), .ex_uc_S_MXRB(ex_uc_S_MXRB),
        .ex_uc_W_RF(ex_uc_W_RF), .ex_uc_W_RB(ex_uc_W_RB),
        .ex_uc_R_DM(ex_uc_R_DM), .ex_uc_W_DM(ex_uc_W_DM),
        .ex_alu_flags(ex_alu_flags), .stall(stall), .dm_req(dm_req),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .wb_valid(wb_valid),
        .wb_mxpc_out(wb_mxpc_out), .wb_dm_Q(wb_dm_Q),
        .wb_alu_result(wb_alu_result), .wb_uc_S_MXRB(wb_uc_S_MXRB),
        .wb_uc_W_RF(wb_uc_W_RF), .wb_uc_W_RB(wb_uc_W_RB),
        .wb_alu_O(wb_alu_O), .wb_alu_S(wb_alu_S), .wb_alu_C(wb_alu_C),
        .wb_alu_Z(wb_alu_Z), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] mxpc;
        logic [31:0] dmq;
        logic [31:0] alu;
        logic [1:0]  smx;
        logic [2:0]  wrf;
        logic        wrb;
        logic [3:0]  flags;
        logic        err;
        int          cyc;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        int          len;
    } req_exp_t;

    wb_exp_t     sb_q[$];
    req_exp_t    req_q[$];
    bit [31:0]   mem_ref[bit [31:0]];
    bit [31:0]   mem_rsp[bit [31:0]];
    int          wait_cfg = 0;
    bit          spur_en = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] dmq_hold = 32'h0;
    int          cyc = 0;

    function automatic bit [31:0] init_word(input bit [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit [31:0] ref_rd(input bit [31:0] a);
        if (mem_ref.exists(a)) return mem_ref[a];
        return init_word(a);
    endfunction

    function automatic bit [31:0] rsp_rd(input bit [31:0] a);
        if (mem_rsp.exists(a)) return mem_rsp[a];
        return init_word(a);
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] all_outputs();
        return {stall, dm_req, dm_we, dm_addr, dm_wdata, wb_valid, wb_mxpc_out,
                wb_dm_Q, wb_alu_result, wb_uc_S_MXRB, wb_uc_W_RF, wb_uc_W_RB,
                wb_alu_O, wb_alu_S, wb_alu_C, wb_alu_Z, bus_err};
    endfunction

    // Monitor: every WB cycle is either a queued retirement or a silent bubble.
    wb_exp_t mon_e;
    always @(negedge CLK) begin
        cyc++;
        if (RST_N) begin
            if (wb_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wb_unexpected actual=wb_valid required=bubble alu=%0h", wb_alu_result);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("wb_record",
                          {wb_mxpc_out, wb_dm_Q, wb_alu_result, wb_uc_S_MXRB, wb_uc_W_RF,
                           wb_uc_W_RB, wb_alu_O, wb_alu_S, wb_alu_C, wb_alu_Z, bus_err},
                          {mon_e.mxpc, mon_e.dmq, mon_e.alu, mon_e.smx, mon_e.wrf,
                           mon_e.wrb, mon_e.flags, mon_e.err});
                    check("wb_latency", cyc, mon_e.cyc);
                end
            end else begin
                check("bubble_no_write", {wb_uc_W_RF, wb_uc_W_RB}, 4'b0000);
            end
        end
    end

    // Data-memory responder: checks each request and acks after the configured wait.
    int       rq_n = 0;
    bit       in_req = 1'b0;
    req_exp_t cur_rq;
    always @(negedge CLK) begin
        if (!RST_N) begin
            in_req = 1'b0;
            rq_n   = 0;
            dm_ack = 1'b0;
        end else if (dm_req) begin
            if (!in_req) begin
                in_req = 1'b1;
                rq_n   = 0;
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_unexpected actual=req addr=%0h required=no request", dm_addr);
                    cur_rq = '{addr: dm_addr, wdata: dm_wdata, we: dm_we, len: rq_n};
                end else begin
                    cur_rq = req_q.pop_front();
                end
            end
            check("req_fields", {dm_addr, dm_we, dm_we ? dm_wdata : 32'h0},
                  {cur_rq.addr, cur_rq.we, cur_rq.we ? cur_rq.wdata : 32'h0});
            if (rq_n == wait_cfg) begin
                dm_ack = 1'b1;
                if (dm_we) mem_rsp[dm_addr] = dm_wdata;
                else dm_rdata = rsp_rd(dm_addr);
            end else begin
                dm_ack   = 1'b0;
                dm_rdata = $urandom;
            end
            rq_n++;
        end else begin
            if (in_req) begin
                check("req_length", rq_n, cur_rq.len);
                in_req = 1'b0;
            end
            dm_ack   = spur_en && ($urandom_range(0, 3) == 0);
            dm_rdata = $urandom;
        end
    end

    // Leave EX with an invalid instruction carrying junk, including write bits.
    task automatic junk_bubble();
        ex_valid      = 1'b0;
        ex_alu_result = $urandom;
        ex_uc_W_RF    = 3'($urandom_range(0, 7));
        ex_uc_W_RB    = 1'($urandom_range(0, 1));
        ex_uc_R_DM    = 1'($urandom_range(0, 1));
        ex_uc_W_DM    = 1'($urandom_range(0, 1));
    endtask

    task automatic bubbles(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    // Issue one instruction, model its outcome, wait until EX may advance.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [3:0] flags,
                         input logic [2:0] wrf, input int wt);
        wb_exp_t  e;
        req_exp_t r;
        bit       mem, mis, s;
        int       n, exp_stall;
        mem = rd || wr;
        mis = mem && (addr[1:0] != 2'b00);
        ex_valid      = 1'b1;
        ex_alu_result = addr;
        ex_store_data = sdata;
        ex_mxpc_out   = $urandom;
        ex_uc_S_MXRB  = 2'($urandom_range(0, 3));
        ex_uc_W_RF    = wrf;
        ex_uc_W_RB    = 1'($urandom_range(0, 1));
        ex_uc_R_DM    = rd;
        ex_uc_W_DM    = wr;
        ex_alu_flags  = flags;
        wait_cfg      = wt;
        e.mxpc = ex_mxpc_out; e.alu = addr; e.smx = ex_uc_S_MXRB;
        e.wrf = wrf; e.wrb = ex_uc_W_RB; e.flags = flags;
        if (!mem) begin
            e.dmq = dmq_hold;
            exp_stall = 0;
        end else if (mis) begin
            e.dmq = 32'h0;
            exp_err = 1'b1;
            exp_stall = 1;
        end else begin
            r.addr = addr; r.we = wr; r.wdata = sdata;
            if (wt < 0) begin
                r.len = TMO; e.dmq = 32'h0; exp_err = 1'b1; exp_stall = TMO + 1;
            end else begin
                r.len = wt + 1;
                exp_stall = wt + 2;
                if (wr) begin
                    e.dmq = 32'h0;
                    mem_ref[addr] = sdata;
                end else begin
                    e.dmq = ref_rd(addr);
                end
            end
            req_q.push_back(r);
        end
        if (mem) dmq_hold = e.dmq;
        e.err = exp_err;
        n = 0;
        forever begin
            @(negedge CLK);
            s = stall;
            @(posedge CLK);
            if (!s) break;
            n++;
            if (n > TMO + 20) begin
                checks++;
                errors++;
                $display("FAIL stall_bound actual=%0d cycles required=at most %0d", n, TMO + 20);
                break;
            end
        end
        check("stall_cycles", n, exp_stall);
        e.cyc = cyc + 1;
        sb_q.push_back(e);
        #1;
        junk_bubble();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int sel, kind;
        #1;
        check("reset_outputs", all_outputs(), 256'h0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        issue(1'b0, 1'b0, 32'h0000_1234, 32'h0, 4'b0101, 3'b111, 0);
        bubbles(1);
        mem_ref[32'h100] = 32'hDEAD_BEEF;
        mem_rsp[32'h100] = 32'hDEAD_BEEF;
        issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h3, 3'b001, 0);
        issue(1'b0, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'h8, 3'b010, 3);
        issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h1, 3'b000, 1);
        issue(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h2, 3'b100, -1);
        issue(1'b0, 1'b0, 32'h0000_5555, 32'h0, 4'hA, 3'b011, 0);
        bubbles(2);
        // Reset in the middle of an outstanding, never-acked load.
        ex_valid = 1'b1; ex_alu_result = 32'h0000_0300; ex_uc_R_DM = 1'b1; ex_uc_W_DM = 1'b0;
        wait_cfg = -1;
        req_q.push_back('{addr: 32'h300, wdata: 32'h0, we: 1'b0, len: 0});
        repeat (3) @(posedge CLK);
        #2;
        check("req_before_reset", dm_req, 1'b1);
        RST_N = 1'b0;
        #1;
        check("reset_mid_access", all_outputs(), 256'h0);
        junk_bubble();
        repeat (2) @(posedge CLK);
        #1;
        req_q.delete();
        sb_q.delete();
        exp_err  = 1'b0;
        dmq_hold = 32'h0;
        RST_N    = 1'b1;
        bubbles(1);
        issue(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h4, 3'b101, 1);
        issue(1'b1, 1'b0, 32'h0000_0102, 32'h0, 4'h5, 3'b110, 0);
        bubbles(1);
        spur_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 19);
            if (sel < 8) begin
                issue(1'b0, 1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)),
                      3'($urandom_range(0, 7)), 0);
            end else begin
                a = 32'($urandom_range(0, 63)) << 2;
                kind = $urandom_range(0, 2);
                if (sel == 17) a[1:0] = 2'($urandom_range(1, 3));
                issue(kind != 1, kind != 0, a, $urandom, 4'($urandom_range(0, 15)),
                      3'($urandom_range(0, 7)), (sel >= 18) ? -1 : $urandom_range(0, 4));
            end
            bubbles($urandom_range(0, 2));
        end
        spur_en = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("queues_drained", sb_q.size() + req_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage directly upstream of the write-back stage. It takes one executed instruction per cycle, performs the load/store on the data memory through a req/ack handshake with variable latency, and stalls upstream while the access is outstanding. It registers everything write-back consumes: PC-link value, load data, ALU result, mux select, flag-write control and ALU flags.

Parameters:
TIMEOUT, 255, number of ACCESS cycles without dm_ack before the access is aborted with a bus error (≥1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
ex_valid  in  1  instruction from EX is valid
ex_alu_result  in  32  ALU result / memory address
ex_store_data  in  32  store data
ex_mxpc_out  in  32  PC-link value
ex_uc_S_MXRB  in  2  write-back mux select, passed through
ex_uc_W_RF  in  3  flag-write control, passed through
ex_uc_W_RB  in  1  register-bank write enable, passed through
ex_uc_R_DM  in  1  load
ex_uc_W_DM  in  1  store (R_DM and W_DM both high: treated as store)
ex_alu_flags  in  4  {O,S,C,Z}
stall  out  1  EX must hold all ex_* stable
dm_req  out  1  memory request
dm_we  out  1  write strobe
dm_addr  out  32  word address
dm_wdata  out  32  write data
dm_ack  in  1  memory completion, one cycle
dm_rdata  in  32  read data, valid with dm_ack
wb_valid  out  1  WB register holds a real instruction
wb_mxpc_out, wb_dm_Q, wb_alu_result  out  32 each  to WB
wb_uc_S_MXRB  out  2;  wb_uc_W_RF  out  3;  wb_uc_W_RB  out  1
wb_alu_O, wb_alu_S, wb_alu_C, wb_alu_Z  out  1 each
bus_err  out  1  sticky error flag

Behaviour:
- Reset (async, RST_N low): state IDLE, timeout counter 0, every output 0. Takes effect mid-access: dm_req drops immediately; memory must tolerate an aborted request.
- FSM states: IDLE, ACCESS, DONE. mem_op = ex_valid & (R_DM | W_DM).
- IDLE, ex_valid & !mem_op: WB register loads ex_* next edge; wb_valid←1; stall=0. Latency 1 cycle.
- IDLE, ex_valid=0: wb_valid←0; other WB registers hold.
- IDLE, mem_op, aligned (addr[1:0]=0): stall=1 (combinational); wb_valid←0. Latch dm_addr, dm_wdata, dm_we; dm_req←1; go to ACCESS.
- IDLE, mem_op, misaligned: stall=1; no request issued; bus_err←1; captured data←0; go to DONE.
- ACCESS: stall=1; dm_req/addr/we/wdata held stable; wb_valid←0; counter increments.
  - On dm_ack: captured data ← dm_rdata for loads, 0 for stores; dm_req←0; counter←0; go to DONE.
  - Counter reaching TIMEOUT without ack: dm_req←0; bus_err←1; captured data←0; go to DONE.
  - Ack in the same cycle the counter reaches TIMEOUT: ack wins, no error.
- DONE: stall=0 (EX advances at this edge); WB register loads ex_* with wb_dm_Q←captured data; wb_valid←1; go to IDLE.
- dm_ack outside ACCESS is ignored.
- Bubbles (wb_valid←0) also force wb_uc_W_RF←0 and wb_uc_W_RB←0, so WB never writes on a bubble.
- Timing, load with ack in first request cycle k=1: stall high cycles 0–1, wb_valid high cycle 3. General rule: ack in cycle k gives wb_valid in cycle k+2.
- bus_err clears only on reset. The faulting instruction still retires with wb_dm_Q=0.

Decomposition:
- Shared package: FSM state encoding; flag bit indices O=3, S=2, C=1, Z=0.
- Sub-module dm_handshake: ACCESS/timeout FSM plus the dm_* interface registers.
- mem_stage keeps the WB pipeline register and the bubble logic.

Test Plan:
- ALU op: ex_valid, alu_result=0x00001234, W_RF=3'b111, flags=4'b0101 → next cycle wb_valid=1, wb_alu_result=0x1234, wb_alu_S=1, wb_alu_Z=1; stall never high.
- Zero-wait load: addr 0x100, dm_ack in first req cycle with rdata 0xDEADBEEF → dm_addr=0x100, dm_we=0, stall high 2 cycles, wb_dm_Q=0xDEADBEEF with wb_valid in cycle 3.
- Store, 3 wait states, data 0xCAFEF00D → dm_req high 4 cycles with addr/wdata stable, dm_we=1, stall high 5 cycles, wb_dm_Q=0.
- TIMEOUT=8, load never acked → dm_req drops after 8 ACCESS cycles, bus_err=1, wb_dm_Q=0, wb_valid pulses once; a following ALU op completes normally.
- Misaligned load at 0x102 → dm_req never asserted, bus_err=1, stall high exactly 1 cycle.
- RST_N low while dm_req=1 → all outputs 0 immediately; after release, a load to 0x200 completes correctly; ex_valid toggling during bubbles never produces wb_uc_W_RB=1 with wb_valid=0.
